// File: rtl/mmio_host_endpoint.sv
// mmio_host_endpoint
// Memory-mapped host endpoint for a multicore test harness. Each accepted
// command is decoded into hex-print, char-print or finish, steered to the core
// slot picked by address bits [3 +: L], and answered through a single-entry
// response buffer. A sticky per-core finish vector and an all-finished flag
// track program completion.
// Optional: define BP_HOST_TRACE_EN for a simulation-only console trace.
// Without it the block produces no simulation output, and the hardware is the
// same either way.
module mmio_host_endpoint #(
  parameter int num_core_p    = 4,
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64,
  parameter int meta_width_p  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [paddr_width_p-1:0] cmd_addr_i,
  input  logic [data_width_p-1:0]  cmd_data_i,
  input  logic [meta_width_p-1:0]  cmd_meta_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_yumi_o,
  output logic [paddr_width_p-1:0] resp_addr_o,
  output logic [meta_width_p-1:0]  resp_meta_o,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_v_o,
  input  logic                     resp_ready_i,
  output logic [num_core_p-1:0]    hprint_v_o,
  output logic [num_core_p-1:0]    cprint_v_o,
  output logic [7:0]               print_data_o,
  output logic [num_core_p-1:0]    finish_v_o,
  output logic                     finish_fail_o,
  output logic [num_core_p-1:0]    program_finish_o,
  output logic                     all_finished_o
);

  localparam int LG = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam int DW = paddr_width_p - 12;
  localparam logic [DW-1:0] HPRINT_DEV = DW'(20'h00100);
  localparam logic [DW-1:0] CPRINT_DEV = DW'(20'h00101);
  localparam logic [DW-1:0] FINISH_DEV = DW'(20'h00102);

  logic [DW-1:0]           dev_addr;
  logic [LG-1:0]           core_idx;
  logic                    hprint_hit, cprint_hit, finish_hit;
  logic [num_core_p-1:0]   hprint_dec, cprint_dec, finish_dec;

  logic                     resp_full_q, resp_full_d;
  logic [paddr_width_p-1:0] resp_addr_q, resp_addr_d;
  logic [meta_width_p-1:0]  resp_meta_q, resp_meta_d;
  logic [num_core_p-1:0]    program_finish_q, program_finish_d;
  logic                     all_finished_q;

  // Only a few data/address bits drive logic; the rest are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{cmd_data_i, cmd_addr_i};

  assign dev_addr   = cmd_addr_i[paddr_width_p-1:12];
  assign core_idx   = cmd_addr_i[3 +: LG];
  assign hprint_hit = (dev_addr == HPRINT_DEV);
  assign cprint_hit = (dev_addr == CPRINT_DEV);
  assign finish_hit = (dev_addr == FINISH_DEV);

  // Per-region one-hot core select; an index beyond the core count selects nobody.
  always_comb begin
    hprint_dec = '0;
    cprint_dec = '0;
    finish_dec = '0;
    for (int i = 0; i < num_core_p; i++) begin
      hprint_dec[i] = cmd_v_i & hprint_hit & (core_idx == LG'(i));
      cprint_dec[i] = cmd_v_i & cprint_hit & (core_idx == LG'(i));
      finish_dec[i] = cmd_v_i & finish_hit & (core_idx == LG'(i));
    end
  end

  // No enqueue-on-dequeue bypass: a full buffer always stalls the command.
  assign cmd_yumi_o    = cmd_v_i & ~resp_full_q;
  assign hprint_v_o    = hprint_dec & {num_core_p{cmd_yumi_o}};
  assign cprint_v_o    = cprint_dec & {num_core_p{cmd_yumi_o}};
  assign finish_v_o    = finish_dec & {num_core_p{cmd_yumi_o}};
  assign print_data_o  = cmd_data_i[7:0];
  assign finish_fail_o = cmd_data_i[0];

  // Response buffer next state: fill on accept, drain on handshake, else hold.
  always_comb begin
    resp_full_d = resp_full_q;
    resp_addr_d = resp_addr_q;
    resp_meta_d = resp_meta_q;
    if (cmd_yumi_o) begin
      resp_full_d = 1'b1;
      resp_addr_d = cmd_addr_i;
      resp_meta_d = cmd_meta_i;
    end else if (resp_full_q && resp_ready_i) begin
      resp_full_d = 1'b0;
    end
  end

  assign program_finish_d = program_finish_q | finish_v_o;

  // Response buffer state and sticky finish tracking.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_full_q      <= 1'b0;
      resp_addr_q      <= '0;
      resp_meta_q      <= '0;
      program_finish_q <= '0;
      all_finished_q   <= 1'b0;
    end else begin
      resp_full_q      <= resp_full_d;
      resp_addr_q      <= resp_addr_d;
      resp_meta_q      <= resp_meta_d;
      program_finish_q <= program_finish_d;
      all_finished_q   <= &program_finish_q;
    end
  end

  assign resp_v_o         = resp_full_q;
  assign resp_addr_o      = resp_addr_q;
  assign resp_meta_o      = resp_meta_q;
  assign resp_data_o      = '0;
  assign program_finish_o = program_finish_q;
  assign all_finished_o   = all_finished_q;

`ifdef BP_HOST_TRACE_EN
  // Console trace of strobed cores, sampled mid-cycle when inputs are settled.
  always @(negedge clk_i) begin
    for (int i = 0; i < num_core_p; i++) begin
      if (hprint_v_o[i]) $display("[CORE%0d PRT] %x", i, print_data_o);
      if (cprint_v_o[i]) begin
        $write("%c", print_data_o);
      end
      if (finish_v_o[i]) $display("[CORE%0d FSH] %s", i, finish_fail_o ? "FAIL" : "PASS");
    end
    if (all_finished_o) begin
      $display("All cores finished! Terminating...");
      $finish;
    end
  end
`else
`endif

endmodule

// File: tb/tb_mmio_host_endpoint.sv
// Self-checking bench for mmio_host_endpoint. Inputs change 2 ns after the
// falling edge; all checks happen 4 ns after the falling edge, 1 ns before
// the rising edge. Responses are matched against a queue of expected
// {addr, meta} pairs pushed when each command is presented.
module tb_mmio_host_endpoint;

  localparam int NC = 4;
  localparam int AW = 40;
  localparam int DW = 64;
  localparam int MW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [MW-1:0] meta;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_data_i;
  logic [MW-1:0] cmd_meta_i;
  logic          cmd_v_i;
  logic          cmd_yumi_o;
  logic [AW-1:0] resp_addr_o;
  logic [MW-1:0] resp_meta_o;
  logic [DW-1:0] resp_data_o;
  logic          resp_v_o;
  logic          resp_ready_i;
  logic [NC-1:0] hprint_v_o, cprint_v_o, finish_v_o, program_finish_o;
  logic [7:0]    print_data_o;
  logic          finish_fail_o, all_finished_o;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mmio_host_endpoint #(
    .num_core_p(NC), .paddr_width_p(AW), .data_width_p(DW), .meta_width_p(MW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_meta_i(cmd_meta_i),
    .cmd_v_i(cmd_v_i), .cmd_yumi_o(cmd_yumi_o),
    .resp_addr_o(resp_addr_o), .resp_meta_o(resp_meta_o), .resp_data_o(resp_data_o),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .hprint_v_o(hprint_v_o), .cprint_v_o(cprint_v_o), .print_data_o(print_data_o),
    .finish_v_o(finish_v_o), .finish_fail_o(finish_fail_o),
    .program_finish_o(program_finish_o), .all_finished_o(all_finished_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Advance to the input-drive phase of the next cycle.
  task automatic step();
    @(negedge clk_i);
    #2;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    exp_t e;
    cmd_addr_i = a;
    cmd_data_i = d;
    cmd_meta_i = m;
    cmd_v_i    = 1'b1;
    e.addr = a;
    e.meta = m;
    exp_q.push_back(e);
  endtask

  // Response scoreboard: every handshake must match the oldest outstanding command.
  always @(negedge clk_i) begin
    exp_t e;
    #4;
    if (reset_n_i && resp_v_o && resp_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'(resp_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("resp_addr", 64'(resp_addr_o), 64'(e.addr));
        chk("resp_meta", 64'(resp_meta_o), 64'(e.meta));
        chk("resp_data", resp_data_o, 64'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NC-1:0] exp_pf;
    logic [AW-1:0] fa;
    exp_pf       = '0;
    reset_n_i    = 1'b0;
    cmd_addr_i   = '0;
    cmd_data_i   = '0;
    cmd_meta_i   = '0;
    cmd_v_i      = 1'b0;
    resp_ready_i = 1'b1;
    step();
    step();
    reset_n_i = 1'b1;
    step();

    // Idle with a matching address but no valid: nothing may strobe.
    cmd_addr_i = 40'h00_0010_0008;
    #2;
    chk("idle_yumi", 64'(cmd_yumi_o), 64'h0);
    chk("idle_hprint", 64'(hprint_v_o), 64'h0);
    chk("idle_resp_v", 64'(resp_v_o), 64'h0);
    chk("idle_pf", 64'(program_finish_o), 64'h0);
    chk("idle_allf", 64'(all_finished_o), 64'h0);

    // Char print to core 1.
    step();
    drive(40'h00_0010_1008, 64'h41, 16'h1234);
    #2;
    chk("cp_yumi", 64'(cmd_yumi_o), 64'h1);
    chk("cp_cprint", 64'(cprint_v_o), 64'b0010);
    chk("cp_hprint", 64'(hprint_v_o), 64'h0);
    chk("cp_pdata", 64'(print_data_o), 64'h41);
    step();
    cmd_v_i = 1'b0;
    #2;
    chk("cp_resp_v", 64'(resp_v_o), 64'h1);
    chk("cp_resp_addr", 64'(resp_addr_o), 64'h00_0010_1008);
    step();

    // Back-pressure: second command must wait for the buffer to drain.
    resp_ready_i = 1'b0;
    drive(40'h00_0010_0000, 64'hAB, 16'h0A01);
    #2;
    chk("bp_yumi1", 64'(cmd_yumi_o), 64'h1);
    chk("bp_hprint1", 64'(hprint_v_o), 64'b0001);
    step();
    drive(40'h00_0010_0018, 64'h5C, 16'h0A02);
    #2;
    chk("bp_yumi2_stall", 64'(cmd_yumi_o), 64'h0);
    chk("bp_resp_v", 64'(resp_v_o), 64'h1);
    chk("bp_hprint_gated", 64'(hprint_v_o), 64'h0);
    step();
    #2;
    chk("bp_hold_addr", 64'(resp_addr_o), 64'h00_0010_0000);
    chk("bp_yumi2_still", 64'(cmd_yumi_o), 64'h0);
    step();
    resp_ready_i = 1'b1;
    #2;
    chk("bp_yumi_dq_cycle", 64'(cmd_yumi_o), 64'h0);
    step();
    #2;
    chk("bp_yumi2_acc", 64'(cmd_yumi_o), 64'h1);
    chk("bp_hprint2", 64'(hprint_v_o), 64'b1000);
    step();
    cmd_v_i = 1'b0;
    step();

    // Finish writes to every core; core 2 reports failure.
    for (int c = 0; c < NC; c++) begin
      fa = 40'h00_0010_2000 + AW'(c * 8);
      drive(fa, (c == 2) ? 64'h1 : 64'h0, MW'(16'hF000 + c));
      #2;
      chk("fin_yumi", 64'(cmd_yumi_o), 64'h1);
      chk("fin_strobe", 64'(finish_v_o), 64'(1 << c));
      chk("fin_fail", 64'(finish_fail_o), (c == 2) ? 64'h1 : 64'h0);
      exp_pf[c] = 1'b1;
      step();
      cmd_v_i = 1'b0;
      #2;
      chk("fin_pf", 64'(program_finish_o), 64'(exp_pf));
      chk("fin_allf_lag", 64'(all_finished_o), 64'h0);
      step();
    end
    #2;
    chk("fin_allf", 64'(all_finished_o), 64'h1);
    step();

    // Index 4 wraps to core 0 through the truncated field.
    drive(40'h00_0010_2020, 64'h0, 16'h0B01);
    #2;
    chk("wrap_finish", 64'(finish_v_o), 64'b0001);
    step();
    cmd_v_i = 1'b0;
    step();
    // Unmapped region: accepted and answered, no strobes.
    drive(40'h00_0020_0000, 64'h77, 16'h0B02);
    #2;
    chk("nomap_yumi", 64'(cmd_yumi_o), 64'h1);
    chk("nomap_strobes", 64'({hprint_v_o, cprint_v_o, finish_v_o}), 64'h0);
    step();
    cmd_v_i = 1'b0;
    step();
    step();
    chk("sb_drain", 64'(exp_q.size()), 64'h0);

    // Asynchronous reset with a response pending and finish bits set.
    resp_ready_i = 1'b0;
    drive(40'h00_0010_0008, 64'h12, 16'h0C01);
    step();
    cmd_v_i = 1'b0;
    #2;
    chk("rst_pre_resp_v", 64'(resp_v_o), 64'h1);
    step();
    reset_n_i = 1'b0;
    #1;
    chk("rst_resp_v", 64'(resp_v_o), 64'h0);
    chk("rst_pf", 64'(program_finish_o), 64'h0);
    chk("rst_allf", 64'(all_finished_o), 64'h0);
    chk("rst_resp_addr", 64'(resp_addr_o), 64'h0);
    exp_q.delete();
    step();
    step();
    reset_n_i    = 1'b1;
    resp_ready_i = 1'b1;
    step();
    #2;
    chk("post_rst_resp_v", 64'(resp_v_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
